ahb_demo_control_panel: RTL

Front-panel input stage that sits directly upstream of the AHB master/slave demo system. It turns raw board switches and pushbuttons into the system's conduit inputs: the 16-bit read/write address and the address/data display select. It synchronises and debounces all inputs. Three buttons drive the outputs: load the address from the switches, step it (with hold-to-repeat), and toggle the display select.

---
 rtl/ahb_demo_control_panel.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ahb_demo_control_panel.sv
// ahb_demo_control_panel: front-panel input stage for the AHB demo system.
// Synchronises and debounces switches/buttons and drives the address conduit.
//
// Ports:
//   clk_clk        in   system clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   sw[15:0]       in   raw slide switches (address value for load)
//   key_n[2:0]     in   raw pushbuttons, active-low: 0=load 1=step 2=select
//   rdwr_address   out  registered address
//   add_data_sel   out  registered address/data display select
//   addr_update    out  one-cycle pulse when rdwr_address is written
//   repeat_active  out  high while the step key is auto-repeating
module ahb_demo_control_panel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ADDR_STEP       = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] sw,
    input  logic [2:0]  key_n,
    output logic [15:0] rdwr_address,
    output logic        add_data_sel,
    output logic        addr_update,
    output logic        repeat_active
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                        : REPEAT_PERIOD;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic [15:0]   STEP     = 16'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [15:0]         sw_s1_q, sw_s2_q;
    logic [2:0]          key_s1_q, key_s2_q;
    logic [2:0][DW-1:0]  db_cnt_q;
    logic [2:0]          deb_q, deb_prev_q, press_q, arm_q;
    logic [1:0]          vld_q;

    state_t              state_q;
    logic [HW-1:0]       hold_q;
    logic [15:0]         addr_q, addr_d;
    logic                sel_q, upd_q, rpt_q;
    logic                load, step;

    // Input synchronisers and per-key debounce.
    // A key is armed only once it has been seen released after reset, so a
    // button held through reset cannot produce a press until re-pressed.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            db_cnt_q   <= '0;
            deb_q      <= '1;
            deb_prev_q <= '1;
            press_q    <= '0;
            arm_q      <= '0;
            vld_q      <= '0;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            for (int k = 0; k < 3; k++) begin
                if (key_s2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    deb_q[k]    <= key_s2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
            deb_prev_q <= deb_q;
            press_q    <= deb_prev_q & ~deb_q & arm_q;
            // vld_q[1] marks that key_s2_q holds real input, not reset fill
            vld_q      <= {vld_q[0], 1'b1};
            arm_q      <= arm_q | ({3{vld_q[1]}} & key_s2_q);
        end
    end

    // Release has priority over a pending repeat step.
    always_comb begin
        load = press_q[0];
        step = 1'b0;
        unique case (state_q)
            IDLE:    step = press_q[1];
            REPEAT:  step = !deb_q[1] && (hold_q == PER_LAST);
            default: step = 1'b0;
        endcase
        addr_d = addr_q;
        if (load) begin
            addr_d = sw_s2_q;
        end else if (step) begin
            addr_d = addr_q + STEP;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            upd_q   <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            upd_q  <= load | step;
            if (press_q[2]) begin
                sel_q <= ~sel_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (press_q[1]) begin
                        state_q <= HOLD;
                        hold_q  <= '0;
                    end
                end
                HOLD: begin
                    if (deb_q[1]) begin
                        state_q <= IDLE;
                    end else if (hold_q == DLY_LAST) begin
                        state_q <= REPEAT;
                        rpt_q   <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (deb_q[1]) begin
                        state_q <= IDLE;
                        rpt_q   <= 1'b0;
                    end else if (hold_q == PER_LAST) begin
                        hold_q <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rpt_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdwr_address  = addr_q;
    assign add_data_sel  = sel_q;
    assign addr_update   = upd_q;
    assign repeat_active = rpt_q;

endmodule
